// File: rtl/wb_sram_target_pkg.sv
// Shared Wishbone cycle-type and burst-type encodings and the slave FSM states.
// Imported by the SRAM target, its address generator and the bench.
package wb_sram_target_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_BURST,
        ST_ERRS
    } state_e;

endpackage

// File: rtl/wb_sram_target_if.sv
// Wishbone B4 bus bundle with registered-feedback burst tags.
// The master drives address/control/write data; the slave returns read data, ACK and ERR.
interface wb_sram_target_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;

    modport master (output adr, cti, bte, dat_w, sel, cyc, stb, we,
                    input  dat_r, ack, err);
    modport slave  (input  adr, cti, bte, dat_w, sel, cyc, stb, we,
                    output dat_r, ack, err);
endinterface

// File: rtl/wb_sram_target_addr_gen.sv
// Next burst word index from the current index and BTE; compiled only with WB_SRAM_TARGET_BURST_EN.
// Purely combinational; no flow control of its own.
module wb_sram_target_addr_gen
    import wb_sram_target_pkg::*;
#(
    parameter int IDXW = 30
) (
    input  logic [IDXW-1:0] i_idx,
    input  logic [1:0]      i_bte,
    output logic [IDXW-1:0] o_nxt
);
    logic [IDXW-1:0] w_mask;
    logic [IDXW-1:0] w_inc;

    // Wrapping bursts only increment inside the aligned block selected by the mask.
    always_comb begin
        case (bte_e'(i_bte))
            BTE_WRAP4:  w_mask = IDXW'(3);
            BTE_WRAP8:  w_mask = IDXW'(7);
            BTE_WRAP16: w_mask = IDXW'(15);
            default:    w_mask = '1;
        endcase
    end

    assign w_inc = i_idx + IDXW'(1);
    assign o_nxt = (i_idx & ~w_mask) | (w_inc & w_mask);

endmodule

// File: rtl/wb_sram_target.sv
// Wishbone B4 SRAM slave; out-of-range words answer ERR. Bursts enabled by WB_SRAM_TARGET_BURST_EN.
// Latency: first ACK/ERR 1+WAIT_STATES cycles after STB, then one beat per cycle in a burst.
// Backpressure: none from the master side; the slave paces the bus purely with ACK/ERR.
module wb_sram_target
    import wb_sram_target_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int MEM_WORDS     = 1024,
    parameter int WAIT_STATES   = 0
) (
    input  logic                clk,
    input  logic                rstn,
    wb_sram_target_if.slave     s
);
    localparam int LANES = WB_DATA_WIDTH / 8;
    localparam int LSB   = $clog2(LANES);
    localparam int IDXW  = WB_ADDR_WIDTH - LSB;
    localparam int MIW   = $clog2(MEM_WORDS);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e                   r_state, w_state_nxt;
    logic [IDXW-1:0]          r_idx;
    logic [3:0]               r_wcnt;
    logic                     r_we;
    logic [WB_DATA_WIDTH-1:0] r_dat;
    logic [WB_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    logic [IDXW-1:0] w_bus_idx, w_rd_idx;
    logic            w_req, w_oor, w_ack, w_err, w_wr, w_lat, w_rd_en, w_unused;

    assign w_bus_idx = s.adr[WB_ADDR_WIDTH-1:LSB];
    assign w_req     = s.cyc & s.stb;
    assign w_oor     = r_idx >= IDXW'(MEM_WORDS);

`ifdef WB_SRAM_TARGET_BURST_EN
    logic [1:0]      r_bte;
    logic [IDXW-1:0] w_nxt;
    logic            w_nxt_oor, w_adv;

    wb_sram_target_addr_gen #(.IDXW(IDXW)) u_addr_gen (
        .i_idx (r_idx),
        .i_bte (r_bte),
        .o_nxt (w_nxt)
    );
    assign w_nxt_oor = w_nxt >= IDXW'(MEM_WORDS);
    assign w_unused  = ^s.adr[LSB-1:0];
`else
    assign w_unused  = ^{s.adr[LSB-1:0], s.cti, s.bte};
`endif

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        w_wr        = 1'b0;
        w_lat       = 1'b0;
        w_rd_en     = 1'b0;
        w_rd_idx    = r_idx;
`ifdef WB_SRAM_TARGET_BURST_EN
        w_adv       = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_lat = 1'b1;
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_rd_en     = 1'b1;
                        w_rd_idx    = w_bus_idx;
                    end
                end
            end
            ST_WAIT: begin
                if (!s.cyc) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wcnt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                    w_rd_en     = 1'b1;
                end
            end
            ST_RESP: begin
                w_ack       = !w_oor;
                w_err       = w_oor;
                w_state_nxt = ST_IDLE;
                if (w_req && !w_oor) begin
                    w_wr = r_we;
`ifdef WB_SRAM_TARGET_BURST_EN
                    if (s.cti == CTI_INCR) begin
                        w_adv       = 1'b1;
                        w_rd_en     = 1'b1;
                        w_rd_idx    = w_nxt;
                        w_state_nxt = w_nxt_oor ? ST_ERRS : ST_BURST;
                    end
`endif
                end
            end
`ifdef WB_SRAM_TARGET_BURST_EN
            ST_BURST: begin
                if (!s.cyc) begin
                    w_state_nxt = ST_IDLE;
                end else if (s.stb && (w_bus_idx != r_idx)) begin
                    // Master strayed from the predicted address: refuse the beat.
                    w_err       = 1'b1;
                    w_state_nxt = ST_ERRS;
                end else begin
                    w_ack       = 1'b1;
                    w_state_nxt = ST_IDLE;
                    if (s.stb) begin
                        w_wr = r_we;
                        if (s.cti == CTI_INCR) begin
                            w_adv       = 1'b1;
                            w_rd_en     = 1'b1;
                            w_rd_idx    = w_nxt;
                            w_state_nxt = w_nxt_oor ? ST_ERRS : ST_BURST;
                        end
                    end
                end
            end
            ST_ERRS: begin
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_idx  <= '0;
            r_we   <= 1'b0;
            r_wcnt <= 4'd0;
            r_dat  <= '0;
`ifdef WB_SRAM_TARGET_BURST_EN
            r_bte  <= 2'b00;
`endif
        end else begin
            if (w_lat) begin
                r_idx  <= w_bus_idx;
                r_we   <= s.we;
                r_wcnt <= WS_LOAD;
`ifdef WB_SRAM_TARGET_BURST_EN
                r_bte  <= s.bte;
            end else if (w_adv) begin
                r_idx  <= w_nxt;
`endif
            end else if (r_state == ST_WAIT && r_wcnt != 4'd0) begin
                r_wcnt <= r_wcnt - 4'd1;
            end
            if (w_rd_en) r_dat <= r_mem[w_rd_idx[MIW-1:0]];
        end
    end

    // Memory is deliberately not reset; a write in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (rstn && w_wr) begin
            for (int b = 0; b < LANES; b++) begin
                if (s.sel[b]) r_mem[r_idx[MIW-1:0]][8*b +: 8] <= s.dat_w[8*b +: 8];
            end
        end
    end

    assign s.ack   = w_ack;
    assign s.err   = w_err;
    assign s.dat_r = w_ack ? r_dat : '0;

endmodule

// File: tb/tb_wb_sram_target.sv
// Directed bench for wb_sram_target: one instance with no wait states, one with three.
// Burst steps run only when WB_SRAM_TARGET_BURST_EN is defined for the build.
module tb_wb_sram_target;
    import wb_sram_target_pkg::*;

    logic clk;
    logic rstn;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [31:0] rd;
    logic        a_o, e_o, t_o, got;
    int          lat;
    int          wrap_w [3] = '{7, 4, 5};

    wb_sram_target_if #(.AW(32), .DW(32)) b0 ();
    wb_sram_target_if #(.AW(32), .DW(32)) b3 ();

    wb_sram_target #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_WORDS(1024), .WAIT_STATES(0))
        dut0 (.clk(clk), .rstn(rstn), .s(b0));
    wb_sram_target #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .MEM_WORDS(1024), .WAIT_STATES(3))
        dut3 (.clk(clk), .rstn(rstn), .s(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Classic single access on either bus; lat counts cycles from the STB sampling edge's cycle.
    task automatic xfer(input bit u3, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic [31:0] rdat, output logic ack_o,
                        output logic err_o, output int lat_o, output logic tail);
        @(posedge clk); #1;
        if (u3) begin
            b3.cyc = 1; b3.stb = 1; b3.we = we; b3.adr = adr; b3.dat_w = dat; b3.sel = sel;
            b3.cti = CTI_CLASSIC; b3.bte = BTE_LINEAR;
        end else begin
            b0.cyc = 1; b0.stb = 1; b0.we = we; b0.adr = adr; b0.dat_w = dat; b0.sel = sel;
            b0.cti = CTI_CLASSIC; b0.bte = BTE_LINEAR;
        end
        lat_o = 0; ack_o = 0; err_o = 0; rdat = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            err_o = err_o | (u3 ? b3.err : b0.err);
            if (u3 ? (b3.ack | b3.err) : (b0.ack | b0.err)) begin
                ack_o = u3 ? b3.ack : b0.ack;
                rdat  = u3 ? b3.dat_r : b0.dat_r;
                break;
            end
            lat_o++;
        end
        @(posedge clk); #1;
        if (u3) begin b3.cyc = 0; b3.stb = 0; b3.we = 0; end
        else    begin b0.cyc = 0; b0.stb = 0; b0.we = 0; end
        @(negedge clk);
        tail = u3 ? (b3.ack | b3.err) : (b0.ack | b0.err);
    endtask

    initial begin
        rstn = 0;
        b0.cyc = 0; b0.stb = 0; b0.we = 0; b0.adr = '0; b0.dat_w = '0; b0.sel = '0;
        b0.cti = CTI_CLASSIC; b0.bte = BTE_LINEAR;
        b3.cyc = 0; b3.stb = 0; b3.we = 0; b3.adr = '0; b3.dat_w = '0; b3.sel = '0;
        b3.cti = CTI_CLASSIC; b3.bte = BTE_LINEAR;
        repeat (3) @(posedge clk);
        #1 rstn = 1;
        @(negedge clk);
        chk("rst_ack0", 32'(b0.ack), 32'd0);
        chk("rst_err0", 32'(b0.err), 32'd0);
        chk("rst_dat0", b0.dat_r, 32'd0);
        chk("rst_ack3", 32'(b3.ack), 32'd0);
        chk("rst_err3", 32'(b3.err), 32'd0);

        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, a_o, e_o, lat, t_o);
        chk("wr10_ack", 32'(a_o), 32'd1);
        chk("wr10_err", 32'(e_o), 32'd0);
        chk("wr10_lat", 32'(lat), 32'd1);
        chk("wr10_one_cycle", 32'(t_o), 32'd0);

        xfer(0, 0, 32'h10, 32'h0, 4'b1111, rd, a_o, e_o, lat, t_o);
        chk("rd10_dat", rd, 32'hDEADBEEF);
        chk("rd10_lat", 32'(lat), 32'd1);
        chk("idle_dat_zero", b0.dat_r, 32'd0);

        xfer(0, 1, 32'h10, 32'h0000AA00, 4'b0010, rd, a_o, e_o, lat, t_o);
        xfer(0, 0, 32'h10, 32'h0, 4'b1111, rd, a_o, e_o, lat, t_o);
        chk("partial_dat", rd, 32'hDEADAAEF);

        xfer(1, 1, 32'h0, 32'h12345678, 4'b1111, rd, a_o, e_o, lat, t_o);
        chk("ws3_wr_lat", 32'(lat), 32'd4);
        xfer(1, 0, 32'h0, 32'h0, 4'b1111, rd, a_o, e_o, lat, t_o);
        chk("ws3_rd_lat", 32'(lat), 32'd4);
        chk("ws3_rd_dat", rd, 32'h12345678);
        chk("ws3_no_err", 32'(e_o), 32'd0);
        chk("ws3_one_cycle", 32'(t_o), 32'd0);

        xfer(0, 0, 32'h1000, 32'h0, 4'b1111, rd, a_o, e_o, lat, t_o);
        chk("oor_err", 32'(e_o), 32'd1);
        chk("oor_no_ack", 32'(a_o), 32'd0);
        chk("oor_lat", 32'(lat), 32'd1);
        chk("oor_dat_zero", rd, 32'd0);
        chk("oor_one_cycle", 32'(t_o), 32'd0);
        xfer(0, 0, 32'h10, 32'h0, 4'b1111, rd, a_o, e_o, lat, t_o);
        chk("after_oor_ack", 32'(a_o), 32'd1);
        chk("after_oor_dat", rd, 32'hDEADAAEF);

        xfer(0, 1, 32'hFFC, 32'hCAFEF00D, 4'b1111, rd, a_o, e_o, lat, t_o);
        xfer(0, 0, 32'hFFC, 32'h0, 4'b1111, rd, a_o, e_o, lat, t_o);
        chk("last_word_ack", 32'(a_o), 32'd1);
        chk("last_word_dat", rd, 32'hCAFEF00D);

        // Reset lands on the edge that would commit a write; the old value must survive.
        xfer(0, 1, 32'h20, 32'h11111111, 4'b1111, rd, a_o, e_o, lat, t_o);
        @(posedge clk); #1;
        b0.cyc = 1; b0.stb = 1; b0.we = 1; b0.adr = 32'h20; b0.dat_w = 32'h22222222; b0.sel = 4'hF;
        @(posedge clk); #1;
        rstn = 0;
        @(posedge clk); #1;
        rstn = 1; b0.cyc = 0; b0.stb = 0; b0.we = 0;
        @(negedge clk);
        chk("midrst_ack", 32'(b0.ack), 32'd0);
        chk("midrst_err", 32'(b0.err), 32'd0);
        xfer(0, 0, 32'h20, 32'h0, 4'b1111, rd, a_o, e_o, lat, t_o);
        chk("midrst_wr_dropped", rd, 32'h11111111);

`ifdef WB_SRAM_TARGET_BURST_EN
        for (int i = 4; i < 8; i++) xfer(0, 1, 32'(i * 4), 32'hB0000000 | 32'(i), 4'hF, rd, a_o, e_o, lat, t_o);
        @(posedge clk); #1;
        b0.cyc = 1; b0.stb = 1; b0.we = 0; b0.adr = 32'd24; b0.cti = CTI_INCR; b0.bte = BTE_WRAP4;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b0.ack) begin got = 1; break; end
        end
        chk("wrap_first_ack", 32'(got), 32'd1);
        chk("wrap_beat0", b0.dat_r, 32'hB0000006);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            b0.adr = 32'(wrap_w[k] * 4);
            b0.cti = (k == 2) ? CTI_EOB : CTI_INCR;
            @(negedge clk);
            chk("wrap_ack", 32'(b0.ack), 32'd1);
            chk("wrap_dat", b0.dat_r, 32'hB0000000 | 32'(wrap_w[k]));
        end
        @(posedge clk); #1;
        b0.cyc = 0; b0.stb = 0; b0.cti = CTI_CLASSIC; b0.bte = BTE_LINEAR;
        @(negedge clk);
        chk("wrap_end_ack", 32'(b0.ack), 32'd0);

        for (int i = 40; i < 43; i++) xfer(0, 1, 32'(i * 4), 32'h0, 4'hF, rd, a_o, e_o, lat, t_o);
        @(posedge clk); #1;
        b0.cyc = 1; b0.stb = 1; b0.we = 1; b0.adr = 32'd160; b0.dat_w = 32'hC0DE0028; b0.sel = 4'hF;
        b0.cti = CTI_INCR; b0.bte = BTE_LINEAR;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b0.ack) begin got = 1; break; end
        end
        chk("lin_first_ack", 32'(got), 32'd1);
        @(posedge clk); #1;
        b0.adr = 32'd164; b0.dat_w = 32'hC0DE0029;
        @(negedge clk);
        chk("lin_beat1_ack", 32'(b0.ack), 32'd1);
        @(posedge clk); #1;
        b0.cyc = 0; b0.stb = 0; b0.we = 0; b0.adr = 32'd168; b0.dat_w = 32'hC0DE002A;
        b0.cti = CTI_CLASSIC;
        @(negedge clk);
        chk("lin_abort_ack", 32'(b0.ack), 32'd0);
        chk("lin_abort_err", 32'(b0.err), 32'd0);
        xfer(0, 0, 32'd160, 32'h0, 4'hF, rd, a_o, e_o, lat, t_o);
        chk("lin_idle_lat", 32'(lat), 32'd1);
        chk("lin_w40", rd, 32'hC0DE0028);
        xfer(0, 0, 32'd164, 32'h0, 4'hF, rd, a_o, e_o, lat, t_o);
        chk("lin_w41", rd, 32'hC0DE0029);
        xfer(0, 0, 32'd168, 32'h0, 4'hF, rd, a_o, e_o, lat, t_o);
        chk("lin_w42_untouched", rd, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
